// File: rtl/connect4_move_sequencer.sv
// Connect-4 turn sequencer: accepts column requests, validates them against the board,
// strobes the placement datapath, waits for the winner detector, then alternates or ends.
module connect4_move_sequencer #(
    parameter int NUM_COLS       = 4,
    parameter int NUM_ROWS       = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [3:0]  move_col,
    output logic        move_ready,
    input  logic [15:0] game_board,
    input  logic [1:0]  game_status,
    output logic        dp_enable,
    output logic [3:0]  dp_column,
    output logic        player_turn,
    output logic        move_reject,
    output logic        turn_timeout,
    output logic        board_clear,
    output logic        game_over,
    output logic [1:0]  final_status,
    output logic [4:0]  move_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_CHECK  = 3'd1,
        S_COMMIT = 3'd2,
        S_SETTLE = 3'd3,
        S_EVAL   = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0]  FULL_COUNT  = 5'd16;

    state_t      r_state, w_next;
    logic [3:0]  r_col;
    logic [3:0]  r_dp_column;
    logic        r_dp_enable, r_reject, r_timeout, r_clear, r_player;
    logic [1:0]  r_final;
    logic [4:0]  r_count;
    logic [3:0]  r_settle;
    logic [15:0] r_to_cnt;

    logic        w_handshake, w_col_ok, w_to_fire, w_settle_done, w_game_end;
    logic [7:0]  w_top_idx;

    assign w_handshake   = move_valid && move_ready;
    assign w_top_idx     = 8'(r_col) * 8'(NUM_ROWS) + 8'(NUM_ROWS - 1);
    // Range test first so the board lookup is only trusted for real columns.
    assign w_col_ok      = ({1'b0, r_col} < 5'(NUM_COLS)) && !game_board[w_top_idx[3:0]];
    assign w_to_fire     = (TIMEOUT_CYCLES > 0) && (r_state == S_WAIT) && !move_valid
                           && (r_to_cnt == TO_LAST);
    assign w_settle_done = (r_settle == 4'd0);
    assign w_game_end    = (game_status != 2'b00) || (r_count == FULL_COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_WAIT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        move_ready = 1'b0;
        game_over  = 1'b0;
        case (r_state)
            S_WAIT: begin
                move_ready = 1'b1;
                if (move_valid) w_next = S_CHECK;
            end
            S_CHECK:  w_next = w_col_ok ? S_COMMIT : S_WAIT;
            S_COMMIT: w_next = S_SETTLE;
            S_SETTLE: if (w_settle_done) w_next = S_EVAL;
            S_EVAL:   w_next = w_game_end ? S_OVER : S_WAIT;
            S_OVER:   game_over = 1'b1;
            default:  w_next = S_WAIT;
        endcase
        if (new_game) w_next = S_WAIT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col       <= '0;
            r_dp_column <= '0;
            r_dp_enable <= 1'b0;
            r_reject    <= 1'b0;
            r_timeout   <= 1'b0;
            r_clear     <= 1'b0;
            r_player    <= 1'b0;
            r_final     <= 2'b00;
            r_count     <= '0;
            r_settle    <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_dp_enable <= 1'b0;
            r_reject    <= 1'b0;
            r_timeout   <= 1'b0;
            r_clear     <= 1'b0;
            if (new_game) begin
                r_player <= 1'b0;
                r_final  <= 2'b00;
                r_count  <= '0;
                r_settle <= '0;
                r_to_cnt <= '0;
                r_clear  <= 1'b1;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (w_handshake) begin
                            r_col    <= move_col;
                            r_to_cnt <= '0;
                        end else if (w_to_fire) begin
                            r_timeout <= 1'b1;
                            r_player  <= ~r_player;
                            r_to_cnt  <= '0;
                        end else if (TIMEOUT_CYCLES > 0) begin
                            r_to_cnt <= r_to_cnt + 16'd1;
                        end
                    end
                    S_CHECK: begin
                        if (w_col_ok) begin
                            r_dp_column <= r_col;
                            r_dp_enable <= 1'b1;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                    S_COMMIT: begin
                        r_count  <= (r_count == FULL_COUNT) ? r_count : r_count + 5'd1;
                        r_settle <= SETTLE_LOAD;
                    end
                    S_SETTLE: if (!w_settle_done) r_settle <= r_settle - 4'd1;
                    S_EVAL: begin
                        if (game_status != 2'b00)     r_final  <= game_status;
                        else if (r_count == FULL_COUNT) r_final <= 2'b11;
                        else                          r_player <= ~r_player;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dp_enable    = r_dp_enable;
    assign dp_column    = r_dp_column;
    assign player_turn  = r_player;
    assign move_reject  = r_reject;
    assign turn_timeout = r_timeout;
    assign board_clear  = r_clear;
    assign final_status = r_final;
    assign move_count   = r_count;
    assign state        = r_state;

endmodule

// File: tb/tb_connect4_move_sequencer.sv
// Directed bench for connect4_move_sequencer: a default instance for move flow and a
// second instance with an 8-cycle turn timeout sharing the same stimulus.
module tb_connect4_move_sequencer;

    logic        clk = 1'b0;
    logic        reset, new_game, move_valid;
    logic [3:0]  move_col;
    logic [15:0] game_board;
    logic [1:0]  game_status;

    logic        move_ready, dp_enable, player_turn, move_reject, turn_timeout, board_clear, game_over;
    logic [3:0]  dp_column;
    logic [1:0]  final_status;
    logic [4:0]  move_count;
    logic [2:0]  state;

    logic        t_move_ready, t_dp_enable, t_player_turn, t_move_reject, t_turn_timeout;
    logic        t_board_clear, t_game_over;
    logic [3:0]  t_dp_column;
    logic [1:0]  t_final_status;
    logic [4:0]  t_move_count;
    logic [2:0]  t_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    connect4_move_sequencer dut (
        .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
        .move_col(move_col), .move_ready(move_ready), .game_board(game_board),
        .game_status(game_status), .dp_enable(dp_enable), .dp_column(dp_column),
        .player_turn(player_turn), .move_reject(move_reject), .turn_timeout(turn_timeout),
        .board_clear(board_clear), .game_over(game_over), .final_status(final_status),
        .move_count(move_count), .state(state)
    );

    connect4_move_sequencer #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
        .move_col(move_col), .move_ready(t_move_ready), .game_board(game_board),
        .game_status(game_status), .dp_enable(t_dp_enable), .dp_column(t_dp_column),
        .player_turn(t_player_turn), .move_reject(t_move_reject), .turn_timeout(t_turn_timeout),
        .board_clear(t_board_clear), .game_over(t_game_over), .final_status(t_final_status),
        .move_count(t_move_count), .state(t_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        new_game    = 1'b0;
        move_valid  = 1'b0;
        move_col    = 4'd0;
        game_board  = '0;
        game_status = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit placed;
        apply_reset();

        // Reset state
        check("rst_state", state, 0);
        check("rst_ready", move_ready, 1);
        check("rst_player", player_turn, 0);
        check("rst_count", move_count, 0);
        check("rst_dpcol", dp_column, 0);
        check("rst_final", final_status, 0);
        check("rst_dpen", dp_enable, 0);
        check("rst_over", game_over, 0);

        // Timeout fires after 8 idle WAIT cycles on the timeout instance only
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("to_pulse", t_turn_timeout, (k == 8) ? 1 : 0);
            check("to_disabled", turn_timeout, 0);
            if (k >= 8) check("to_player", t_player_turn, 1);
        end
        check("to_state", t_state, 0);

        // Handshake on the 8th WAIT cycle suppresses the timeout
        apply_reset();
        repeat (7) @(negedge clk);
        move_valid = 1'b1;
        move_col   = 4'd0;
        @(negedge clk);
        move_valid = 1'b0;
        check("to_supp_pulse", t_turn_timeout, 0);
        check("to_supp_state", t_state, 1);
        check("to_supp_player", t_player_turn, 0);
        @(negedge clk);
        check("to_supp_pulse2", t_turn_timeout, 0);

        // Valid move into column 2 on an empty board
        apply_reset();
        move_valid = 1'b1;
        move_col   = 4'd2;
        @(negedge clk);
        move_valid = 1'b0;
        check("m1_check", state, 1);
        check("m1_dpen_chk", dp_enable, 0);
        @(negedge clk);
        check("m1_commit", state, 2);
        check("m1_dpen", dp_enable, 1);
        check("m1_dpcol", dp_column, 2);
        @(negedge clk);
        check("m1_settle", state, 3);
        check("m1_dpen_off", dp_enable, 0);
        check("m1_count", move_count, 1);
        @(negedge clk);
        check("m1_settle2", state, 3);
        @(negedge clk);
        check("m1_eval", state, 4);
        check("m1_player_eval", player_turn, 0);
        check("m1_ready_eval", move_ready, 0);
        @(negedge clk);
        check("m1_wait", state, 0);
        check("m1_ready", move_ready, 1);
        check("m1_player", player_turn, 1);
        check("m1_dpcol_hold", dp_column, 2);

        // Full column 1 rejected, then out-of-range column 5 with move_valid held
        game_board = 16'h0080;
        move_valid = 1'b1;
        move_col   = 4'd1;
        @(negedge clk);
        check("rj1_check", state, 1);
        @(negedge clk);
        check("rj1_state", state, 0);
        check("rj1_pulse", move_reject, 1);
        check("rj1_ready", move_ready, 1);
        check("rj1_dpen", dp_enable, 0);
        check("rj1_player", player_turn, 1);
        move_col = 4'd5;
        @(negedge clk);
        check("rj2_check", state, 1);
        check("rj2_pulse_off", move_reject, 0);
        @(negedge clk);
        check("rj2_pulse", move_reject, 1);
        check("rj2_dpen", dp_enable, 0);
        check("rj2_count", move_count, 1);
        check("rj2_dpcol", dp_column, 2);
        move_valid = 1'b0;
        game_board = '0;

        // Player 1 wins during SETTLE
        move_valid = 1'b1;
        move_col   = 4'd0;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        check("win_dpen", dp_enable, 1);
        @(negedge clk);
        game_status = 2'b10;
        @(negedge clk);
        @(negedge clk);
        check("win_eval", state, 4);
        @(negedge clk);
        check("win_state", state, 5);
        check("win_over", game_over, 1);
        check("win_final", final_status, 2);
        check("win_ready", move_ready, 0);
        check("win_player", player_turn, 1);
        check("win_count", move_count, 2);
        move_valid = 1'b1;
        move_col   = 4'd3;
        repeat (3) begin
            @(negedge clk);
            check("over_state", state, 5);
            check("over_dpen", dp_enable, 0);
        end
        move_valid = 1'b0;

        // new_game from OVER
        new_game = 1'b1;
        @(negedge clk);
        new_game    = 1'b0;
        game_status = 2'b00;
        check("ng_state", state, 0);
        check("ng_clear", board_clear, 1);
        check("ng_player", player_turn, 0);
        check("ng_count", move_count, 0);
        check("ng_final", final_status, 0);
        check("ng_over", game_over, 0);
        @(negedge clk);
        check("ng_clear_off", board_clear, 0);

        // new_game during SETTLE abandons the move
        move_valid = 1'b1;
        move_col   = 4'd3;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ngs_settle", state, 3);
        check("ngs_count1", move_count, 1);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check("ngs_state", state, 0);
        check("ngs_clear", board_clear, 1);
        check("ngs_count", move_count, 0);
        check("ngs_player", player_turn, 0);
        repeat (4) begin
            @(negedge clk);
            check("ngs_idle_state", state, 0);
            check("ngs_idle_dpen", dp_enable, 0);
        end

        // Asynchronous reset mid-COMMIT
        move_valid = 1'b1;
        move_col   = 4'd1;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        check("rc_dpen", dp_enable, 1);
        check("rc_dpcol", dp_column, 1);
        #1 reset = 1'b1;
        #1;
        check("rc_state", state, 0);
        check("rc_dpen_off", dp_enable, 0);
        check("rc_dpcol_rst", dp_column, 0);
        check("rc_count", move_count, 0);
        check("rc_clear", board_clear, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rc_idle_dpen", dp_enable, 0);
            check("rc_idle_clear", board_clear, 0);
            check("rc_idle_state", state, 0);
        end

        // 16 moves fill the board -> draw
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            move_valid = 1'b1;
            move_col   = 4'(i % 4);
            @(negedge clk);
            move_valid = 1'b0;
            check("draw_check", state, 1);
            @(negedge clk);
            check("draw_dpen", dp_enable, 1);
            check("draw_dpcol", dp_column, i % 4);
            placed = 1'b0;
            for (int r = 0; r < 4; r++) begin
                if (!placed && !game_board[(i % 4) * 4 + r]) begin
                    game_board[(i % 4) * 4 + r] = 1'b1;
                    placed = 1'b1;
                end
            end
            repeat (4) @(negedge clk);
            check("draw_after", state, (i < 15) ? 0 : 5);
        end
        check("draw_board", game_board, 16'hFFFF);
        check("draw_count", move_count, 16);
        check("draw_final", final_status, 3);
        check("draw_over", game_over, 1);
        check("draw_player", player_turn, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
